// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters, holding its inputs ALU_LAT cycles per operation.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] result,
  output logic       err,
  output logic       busy,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    state_t     state;
    logic [3:0] cnt;
    logic       owner;
    logic       err_flag;
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0;
    logic       rvalid1;
    logic [7:0] result;
    logic       err;
    logic       busy;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [2:0] alu_sel;
  } regs_t;

  localparam regs_t      RESET_REGS = '{state: IDLE, default: '0};
  localparam logic [3:0] LAST_CNT   = 4'(ALU_LAT - 1);

  regs_t      r, r_n;
  logic       pick1;
  logic [2:0] op_w;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last, last_n;
`endif

  // Winner selection; only meaningful while at least one request is high.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    pick1 = !req0;
`else
    pick1 = req1 && (!req0 || !last);
`endif
    op_w = pick1 ? op1 : op0;
  end

  always_comb begin
    // NOTE: every field starts from a default, so no path leaves a value unassigned and no latch is inferred.
    r_n         = r;
    r_n.gnt0    = 1'b0;
    r_n.gnt1    = 1'b0;
    r_n.rvalid0 = 1'b0;
    r_n.rvalid1 = 1'b0;
    r_n.err     = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_n      = last;
`endif

    case (r.state)
      IDLE: begin
        if (req0 || req1) begin
          r_n.owner    = pick1;
          r_n.gnt0     = !pick1;
          r_n.gnt1     = pick1;
          r_n.alu_in1  = pick1 ? a1 : a0;
          r_n.alu_in2  = pick1 ? b1 : b0;
          r_n.err_flag = (op_w > 3'd3);
          r_n.alu_sel  = r_n.err_flag ? 3'd0 : op_w;
          r_n.cnt      = '0;
          r_n.state    = EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_n       = pick1;
`endif
        end
      end
      EXEC: begin
        r_n.cnt = r.cnt + 4'd1;
        if (r.cnt == LAST_CNT) begin
          // Unsupported opcodes return zero rather than whatever pass-through the ALU produced.
          r_n.result  = r.err_flag ? 8'h00 : alu_out;
          r_n.err     = r.err_flag;
          r_n.rvalid0 = !r.owner;
          r_n.rvalid1 = r.owner;
          r_n.state   = RESP;
        end
      end
      RESP:    r_n.state = IDLE;
      default: r_n.state = IDLE;
    endcase

    r_n.busy = (r_n.state != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r <= RESET_REGS;
    else        r <= r_n;
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last <= 1'b1;
    else        last <= last_n;
  end
`endif

  assign gnt0    = r.gnt0;
  assign gnt1    = r.gnt1;
  assign rvalid0 = r.rvalid0;
  assign rvalid1 = r.rvalid1;
  assign result  = r.result;
  assign err     = r.err;
  assign busy    = r.busy;
  assign alu_in1 = r.alu_in1;
  assign alu_in2 = r.alu_in2;
  assign alu_sel = r.alu_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (ALU_LAT=1 and ALU_LAT=4), each with its own ALU model, checked cycle by cycle
// against a transaction-timeline reference model. Honours ALU_ARB_FIXED_PRIO_EN like the design.
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  logic       req0    [2];
  logic [2:0] op0     [2];
  logic [7:0] a0      [2];
  logic [7:0] b0      [2];
  logic       req1    [2];
  logic [2:0] op1     [2];
  logic [7:0] a1      [2];
  logic [7:0] b1      [2];
  logic       gnt0    [2];
  logic       gnt1    [2];
  logic       rvalid0 [2];
  logic       rvalid1 [2];
  logic [7:0] result  [2];
  logic       err     [2];
  logic       busy    [2];
  logic [7:0] alu_in1 [2];
  logic [7:0] alu_in2 [2];
  logic [2:0] alu_sel [2];
  logic [7:0] alu_out [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: one in-flight transaction per DUT, described by the edge that granted it.
  int         g_edge [2];
  bit         last   [2];
  bit         win    [2];
  logic [7:0] m_a    [2];
  logic [7:0] m_b    [2];
  logic [2:0] m_sel  [2];
  bit         m_err  [2];
  logic [7:0] m_res  [2];
  logic [7:0] cap    [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return 8'h00;
    endcase
  endfunction

  // The shared ALU the arbiter drives.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      case (alu_sel[d])
        3'd0:    alu_out[d] = alu_in1[d];
        3'd1:    alu_out[d] = alu_in1[d] + alu_in2[d];
        3'd2:    alu_out[d] = alu_in1[d] & alu_in2[d];
        3'd3:    alu_out[d] = alu_in1[d] | alu_in2[d];
        default: alu_out[d] = 8'h5A;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.ALU_LAT(g == 0 ? 1 : 4)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0[g]),
      .op0    (op0[g]),
      .a0     (a0[g]),
      .b0     (b0[g]),
      .req1   (req1[g]),
      .op1    (op1[g]),
      .a1     (a1[g]),
      .b1     (b1[g]),
      .gnt0   (gnt0[g]),
      .gnt1   (gnt1[g]),
      .rvalid0(rvalid0[g]),
      .rvalid1(rvalid1[g]),
      .result (result[g]),
      .err    (err[g]),
      .busy   (busy[g]),
      .alu_in1(alu_in1[g]),
      .alu_in2(alu_in2[g]),
      .alu_sel(alu_sel[g]),
      .alu_out(alu_out[g])
    );
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      g_edge[d] = -1000;
      last[d]   = 1'b1;
      win[d]    = 1'b0;
      m_a[d]    = 8'h00;
      m_b[d]    = 8'h00;
      m_sel[d]  = 3'd0;
      m_err[d]  = 1'b0;
      m_res[d]  = 8'h00;
      cap[d]    = 8'h00;
    end
  endtask

  // Decide what the arbiter does at the coming edge (numbered cyc).
  task automatic model_edge(int d);
    bit         w;
    logic [2:0] op;
    if (cyc >= g_edge[d] + 2 + lat_of(d) && (req0[d] || req1[d])) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = !req0[d];
`else
      w = (req0[d] && req1[d]) ? !last[d] : req1[d];
`endif
      last[d]   = w;
      win[d]    = w;
      g_edge[d] = cyc;
      op        = w ? op1[d] : op0[d];
      m_a[d]    = w ? a1[d] : a0[d];
      m_b[d]    = w ? b1[d] : b0[d];
      m_err[d]  = (op > 3'd3);
      m_sel[d]  = m_err[d] ? 3'd0 : op;
      m_res[d]  = ref_op(op, m_a[d], m_b[d]);
    end
  endtask

  // Expected outputs during cycle cyc, k cycles after the grant edge.
  task automatic check_outputs(int d);
    int lat = lat_of(d);
    int k   = cyc - g_edge[d];
    bit rv  = (k == 1 + lat);
    if (rv) cap[d] = m_res[d];
    check($sformatf("d%0d c%0d gnt0", d, cyc),    8'(gnt0[d]),    8'(k == 1 && !win[d]));
    check($sformatf("d%0d c%0d gnt1", d, cyc),    8'(gnt1[d]),    8'(k == 1 && win[d]));
    check($sformatf("d%0d c%0d rvalid0", d, cyc), 8'(rvalid0[d]), 8'(rv && !win[d]));
    check($sformatf("d%0d c%0d rvalid1", d, cyc), 8'(rvalid1[d]), 8'(rv && win[d]));
    check($sformatf("d%0d c%0d busy", d, cyc),    8'(busy[d]),    8'(k >= 1 && k <= 1 + lat));
    check($sformatf("d%0d c%0d err", d, cyc),     8'(err[d]),     8'(rv && m_err[d]));
    check($sformatf("d%0d c%0d result", d, cyc),  result[d],      cap[d]);
    check($sformatf("d%0d c%0d alu_in1", d, cyc), alu_in1[d],     m_a[d]);
    check($sformatf("d%0d c%0d alu_in2", d, cyc), alu_in2[d],     m_b[d]);
    check($sformatf("d%0d c%0d alu_sel", d, cyc), 8'(alu_sel[d]), 8'(m_sel[d]));
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) model_edge(d);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) check_outputs(d);
  endtask

  // Asynchronous reset for one cycle, starting mid-cycle.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check_outputs(d);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) check_outputs(d);
    reset = 1'b1;
  endtask

  task automatic rand_req(int d, int r);
    logic       q = ($urandom_range(0, 2) != 0);
    logic [2:0] o = 3'($urandom_range(0, 7));
    if (r == 0) begin
      req0[d] = q; op0[d] = o; a0[d] = 8'($urandom); b0[d] = 8'($urandom);
    end else begin
      req1[d] = q; op1[d] = o; a1[d] = 8'($urandom); b1[d] = 8'($urandom);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b0; op0[d] = '0; a0[d] = '0; b0[d] = '0;
      req1[d] = 1'b0; op1[d] = '0; a1[d] = '0; b1[d] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single add on the ALU_LAT=1 arbiter.
    req0[0] = 1'b1; op0[0] = 3'd1; a0[0] = 8'h03; b0[0] = 8'h01;
    tick();
    check("t1 gnt0", 8'(gnt0[0]), 8'h01);
    req0[0] = 1'b0;
    tick();
    check("t1 result", result[0], 8'h04);
    tick();
    tick();

    // Both requesters held high: grants alternate (or stay on 0 with fixed priority).
    req0[0] = 1'b1; op0[0] = 3'd2; a0[0] = 8'h0F; b0[0] = 8'h3C;
    req1[0] = 1'b1; op1[0] = 3'd3; a1[0] = 8'h0F; b1[0] = 8'h3C;
    for (int i = 0; i < 12; i++) tick();
    req0[0] = 1'b0; req1[0] = 1'b0;
    tick();
    tick();

    // Add wraps, then pass-through with REQ1 kept high across the first operation.
    req1[0] = 1'b1; op1[0] = 3'd1; a1[0] = 8'hFF; b1[0] = 8'h02;
    tick();
    op1[0] = 3'd0;
    tick();
    check("t3 wrap", result[0], 8'h01);
    tick();
    tick();
    req1[0] = 1'b0;
    tick();
    check("t3 pass", result[0], 8'hFF);
    tick();

    // Unsupported opcode.
    req0[0] = 1'b1; op0[0] = 3'd5; a0[0] = 8'h77; b0[0] = 8'h11;
    tick();
    req0[0] = 1'b0;
    tick();
    check("t4 err", 8'(err[0]), 8'h01);
    check("t4 result", result[0], 8'h00);
    check("t4 alu_sel", 8'(alu_sel[0]), 8'h00);
    tick();

    // ALU_LAT=4: operands change and REQ drops after the grant.
    req0[1] = 1'b1; op0[1] = 3'd1; a0[1] = 8'h20; b0[1] = 8'h05;
    tick();
    a0[1] = 8'h99; req0[1] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5 rvalid0", 8'(rvalid0[1]), 8'h01);
    check("t5 result", result[1], 8'h25);
    tick();
    tick();

    // Reset during EXEC aborts the operation; a tie afterwards goes to requester 0.
    req0[1] = 1'b1; op0[1] = 3'd3; a0[1] = 8'hF0; b0[1] = 8'h0F;
    tick();
    req0[1] = 1'b0;
    tick();
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b1; op0[d] = 3'd2; a0[d] = 8'hAA; b0[d] = 8'h0F;
      req1[d] = 1'b1; op1[d] = 3'd1; a1[d] = 8'h10; b1[d] = 8'h20;
    end
    tick();
    check("t6 tie d0", 8'(gnt0[0]), 8'h01);
    check("t6 tie d1", 8'(gnt0[1]), 8'h01);
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b0; req1[d] = 1'b0;
    end
    for (int i = 0; i < 6; i++) tick();

    // Random traffic, inputs only change while idle or on the grant.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!req0[d] || gnt0[d]) rand_req(d, 0);
        if (!req1[d] || gnt1[d]) rand_req(d, 1);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b0; req1[d] = 1'b0;
    end
    for (int i = 0; i < 8; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
